// File: rtl/video_timing_pkg.sv
// Shared definitions for the raster timing generator and its consumers.
//   COORD_W            : width of the x/y pixel coordinates
//   DEF_*              : 640x480@60 timing (800x525 total raster)
//   video_timing_t     : sync/de/position bundle handed to pattern and encoder stages
//   fits_coord()       : true when an axis total can be held in a COORD_W counter
package video_timing_pkg;

    localparam int COORD_W = 10;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    typedef struct packed {
        logic               hsync;
        logic               vsync;
        logic               de;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } video_timing_t;

    function automatic bit fits_coord(input int total);
        return (total >= 1) && (total <= (1 << COORD_W));
    endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// One raster axis: a wrapping position counter with decode of the position it
// is about to take, so the parent can register decoded flags in step with the
// count itself.
//   clk         : pixel clock
//   resetn      : synchronous active-low reset (count returns to 0)
//   restart     : force the next count to 0 regardless of advance
//   advance     : step the count this cycle
//   count       : registered position, 0..TOTAL-1
//   wrap        : count is at TOTAL-1 and steps back to 0 this cycle
//   active_next : next position lies in [0, VISIBLE)
//   sync_next   : next position lies in [SYNC_START, SYNC_END)
module timing_axis_counter
    import video_timing_pkg::*;
#(
    parameter int TOTAL      = DEF_H_TOTAL,
    parameter int VISIBLE    = DEF_H_VISIBLE,
    parameter int SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT,
    parameter int SYNC_END   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               restart,
    input  logic               advance,
    output logic [COORD_W-1:0] count,
    output logic               wrap,
    output logic               active_next,
    output logic               sync_next
);

    localparam logic [COORD_W-1:0] LAST = COORD_W'(TOTAL - 1);

    // Window bounds carry one extra bit so an edge equal to 2**COORD_W still fits.
    localparam logic [COORD_W:0] VIS_END = (COORD_W + 1)'(VISIBLE);
    localparam logic [COORD_W:0] SYNC_LO = (COORD_W + 1)'(SYNC_START);
    localparam logic [COORD_W:0] SYNC_HI = (COORD_W + 1)'(SYNC_END);

    logic [COORD_W-1:0] count_p0;
    logic [COORD_W:0]   count_ext_p0;

    always_comb begin
        count_p0 = count;
        if (restart) begin
            count_p0 = '0;
        end else if (advance) begin
            count_p0 = (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign count_ext_p0 = {1'b0, count_p0};
    assign wrap         = advance && !restart && (count == LAST);
    assign active_next  = count_ext_p0 < VIS_END;
    assign sync_next    = (count_ext_p0 >= SYNC_LO) && (count_ext_p0 < SYNC_HI);

    // ---- stage boundary: next position -> registered position ----
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else begin
            count <= count_p0;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Free-running raster timing generator in the pixel clock domain. Produces the
// sync pulses, data enable and pixel coordinates for the downstream pattern
// and TMDS encoder logic. Every output is a flop and all of them describe the
// same (x, y) position in the same cycle.
//   pixclk      : pixel clock, sole clock
//   resetn      : synchronous active-low reset
//   hsync/vsync : sync pulses, asserted level set by HSYNC_POL / VSYNC_POL
//   de          : data enable, high inside the visible window
//   x, y        : current raster position
//   line_start  : high while x == 0
//   frame_start : high while x == 0 and y == 0
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic               pixclk,
    input  logic               resetn,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               line_start,
    output logic               frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    generate
        if (!fits_coord(H_TOTAL)) begin : g_bad_h_total
            $error("video_timing_gen: H_TOTAL=%0d does not fit the coordinate counter", H_TOTAL);
        end
        if (!fits_coord(V_TOTAL)) begin : g_bad_v_total
            $error("video_timing_gen: V_TOTAL=%0d does not fit the coordinate counter", V_TOTAL);
        end
    endgenerate

    // Cleared by reset. While low the counters are steered to (0,0), so the
    // first cycle out of reset already presents the first pixel of a frame
    // instead of skipping straight to (1,0).
    logic running_p1;

    logic restart_p0;
    logic h_wrap_p0;
    logic v_wrap_p0;
    logic h_active_p0;
    logic v_active_p0;
    logic h_sync_p0;
    logic v_sync_p0;
    logic de_p0;
    logic line_start_p0;
    logic frame_start_p0;

    assign restart_p0 = !running_p1;

    timing_axis_counter #(
        .TOTAL      (H_TOTAL),
        .VISIBLE    (H_VISIBLE),
        .SYNC_START (H_VISIBLE + H_FRONT),
        .SYNC_END   (H_VISIBLE + H_FRONT + H_SYNC)
    ) u_h_axis (
        .clk         (pixclk),
        .resetn      (resetn),
        .restart     (restart_p0),
        .advance     (1'b1),
        .count       (x),
        .wrap        (h_wrap_p0),
        .active_next (h_active_p0),
        .sync_next   (h_sync_p0)
    );

    // The vertical axis only steps when the line wraps, so vsync and y change
    // together on the cycle that shows x == 0.
    timing_axis_counter #(
        .TOTAL      (V_TOTAL),
        .VISIBLE    (V_VISIBLE),
        .SYNC_START (V_VISIBLE + V_FRONT),
        .SYNC_END   (V_VISIBLE + V_FRONT + V_SYNC)
    ) u_v_axis (
        .clk         (pixclk),
        .resetn      (resetn),
        .restart     (restart_p0),
        .advance     (h_wrap_p0),
        .count       (y),
        .wrap        (v_wrap_p0),
        .active_next (v_active_p0),
        .sync_next   (v_sync_p0)
    );

    // The next x is 0 exactly when restarting or when the line wraps; the next
    // (x,y) is (0,0) exactly when restarting or when the frame wraps.
    assign de_p0          = h_active_p0 && v_active_p0;
    assign line_start_p0  = restart_p0 || h_wrap_p0;
    assign frame_start_p0 = restart_p0 || v_wrap_p0;

    // ---- stage boundary: decode of next position -> registered outputs ----
    always_ff @(posedge pixclk) begin
        if (!resetn) begin
            running_p1  <= 1'b0;
            de          <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            running_p1  <= 1'b1;
            de          <= de_p0;
            hsync       <= h_sync_p0 ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= v_sync_p0 ? VSYNC_POL : ~VSYNC_POL;
            line_start  <= line_start_p0;
            frame_start <= frame_start_p0;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen. Three instances share clock and reset:
//   index 0 (A): default horizontal timing, short 13-line frame, active-low syncs
//   index 1 (B): 8x6 raster, active-high syncs
//   index 2 (C): full 640x480 defaults
// An independent position model (cycle index since reset release) predicts
// each cycle's outputs; predictions are queued when a cycle is driven and
// compared on the following falling edge.
module tb_video_timing_gen;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic       ls;
        logic       fs;
        logic [9:0] x;
        logic [9:0] y;
    } obs_t;

    bit   pixclk;
    logic resetn;

    logic       hsync_a, vsync_a, de_a, ls_a, fs_a;
    logic [9:0] x_a, y_a;
    logic       hsync_b, vsync_b, de_b, ls_b, fs_b;
    logic [9:0] x_b, y_b;
    logic       hsync_c, vsync_c, de_c, ls_c, fs_c;
    logic [9:0] x_c, y_c;

    obs_t obs [3];
    obs_t sbq [3][$];

    int t;       // cycle index of the position currently shown, -1 = reset state
    int checks;
    int errors;

    always #5 pixclk = ~pixclk;

    video_timing_gen #(
        .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut_a (
        .pixclk(pixclk), .resetn(resetn), .hsync(hsync_a), .vsync(vsync_a), .de(de_a),
        .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a)
    );

    video_timing_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) dut_b (
        .pixclk(pixclk), .resetn(resetn), .hsync(hsync_b), .vsync(vsync_b), .de(de_b),
        .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b)
    );

    video_timing_gen dut_c (
        .pixclk(pixclk), .resetn(resetn), .hsync(hsync_c), .vsync(vsync_c), .de(de_c),
        .x(x_c), .y(y_c), .line_start(ls_c), .frame_start(fs_c)
    );

    always_comb begin
        obs[0] = '{hs: hsync_a, vs: vsync_a, de: de_a, ls: ls_a, fs: fs_a, x: x_a, y: y_a};
        obs[1] = '{hs: hsync_b, vs: vsync_b, de: de_b, ls: ls_b, fs: fs_b, x: x_b, y: y_b};
        obs[2] = '{hs: hsync_c, vs: vsync_c, de: de_c, ls: ls_c, fs: fs_c, x: x_c, y: y_c};
    end

    // Expected outputs of instance k at cycle index tt, straight from the raster formulas.
    function automatic obs_t model(input int k, input int tt);
        obs_t o;
        int hv, hf, hsw, hb, vv, vf, vsw, vb;
        int ht, vt, px, py;
        bit hp, vp;
        case (k)
            0:       begin hv = 640; hf = 16; hsw = 96; hb = 48; vv = 6;   vf = 2;  vsw = 2; vb = 3;  hp = 0; vp = 0; end
            1:       begin hv = 4;   hf = 1;  hsw = 2;  hb = 1;  vv = 3;   vf = 1;  vsw = 1; vb = 1;  hp = 1; vp = 1; end
            default: begin hv = 640; hf = 16; hsw = 96; hb = 48; vv = 480; vf = 10; vsw = 2; vb = 33; hp = 0; vp = 0; end
        endcase
        if (tt < 0) begin
            o = '{hs: !hp, vs: !vp, de: 1'b0, ls: 1'b0, fs: 1'b0, x: 10'd0, y: 10'd0};
            return o;
        end
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        px = tt % ht;
        py = (tt / ht) % vt;
        o.x  = px[9:0];
        o.y  = py[9:0];
        o.de = (px < hv) && (py < vv);
        o.hs = ((px >= hv + hf) && (px < hv + hf + hsw)) ? hp : !hp;
        o.vs = ((py >= vv + vf) && (py < vv + vf + vsw)) ? vp : !vp;
        o.ls = (px == 0);
        o.fs = (px == 0) && (py == 0);
        return o;
    endfunction

    // Drive one clock edge with the given reset level and queue the predictions.
    task automatic step(input logic rn);
        resetn = rn;
        t = rn ? t + 1 : -1;
        for (int k = 0; k < 3; k++) sbq[k].push_back(model(k, t));
        @(posedge pixclk);
        #1;
    endtask

    task automatic sb_monitor();
        obs_t e;
        forever begin
            @(negedge pixclk);
            for (int k = 0; k < 3; k++) begin
                if (sbq[k].size() > 0) begin
                    e = sbq[k].pop_front();
                    checks++;
                    if (obs[k] !== e) begin
                        errors++;
                        $display("FAIL scoreboard dut%0d: got hs=%b vs=%b de=%b ls=%b fs=%b x=%0d y=%0d, expected hs=%b vs=%b de=%b ls=%b fs=%b x=%0d y=%0d",
                                 k, obs[k].hs, obs[k].vs, obs[k].de, obs[k].ls, obs[k].fs, obs[k].x, obs[k].y,
                                 e.hs, e.vs, e.de, e.ls, e.fs, e.x, e.y);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b0);
            checks++;
            if ({hsync_c, vsync_c, de_c, ls_c, fs_c, x_c, y_c} !== {5'b11000, 20'd0}) begin
                errors++;
                $display("FAIL reset_hold_c: got hs=%b vs=%b de=%b ls=%b fs=%b x=%0d y=%0d, expected 1 1 0 0 0 0 0",
                         hsync_c, vsync_c, de_c, ls_c, fs_c, x_c, y_c);
            end
        end
        checks++;
        if ({hsync_b, vsync_b} !== 2'b00) begin
            errors++;
            $display("FAIL reset_sync_b: got hs=%b vs=%b, expected 0 0", hsync_b, vsync_b);
        end
        step(1'b1);
        checks++;
        if ({hsync_c, vsync_c, de_c, ls_c, fs_c, x_c, y_c} !== {5'b11111, 20'd0}) begin
            errors++;
            $display("FAIL first_after_reset_c: got hs=%b vs=%b de=%b ls=%b fs=%b x=%0d y=%0d, expected 1 1 1 1 1 0 0",
                     hsync_c, vsync_c, de_c, ls_c, fs_c, x_c, y_c);
        end
    endtask

    task automatic test_line_timing();
        int n_de = 0, n_hs = 0, n_ls = 0, hs_first = -1, hs_last = -1;
        for (int i = 0; i < 800; i++) begin
            if (de_c === 1'b1) n_de++;
            if (hsync_c === 1'b0) begin
                if (hs_first < 0) hs_first = int'(x_c);
                hs_last = int'(x_c);
                n_hs++;
            end
            if (ls_c === 1'b1) n_ls++;
            step(1'b1);
        end
        checks++;
        if (n_de != 640) begin errors++; $display("FAIL line_de_count: got %0d, expected 640", n_de); end
        checks++;
        if (n_hs != 96) begin errors++; $display("FAIL line_hsync_width: got %0d, expected 96", n_hs); end
        checks++;
        if (hs_first != 656) begin errors++; $display("FAIL line_hsync_first_x: got %0d, expected 656", hs_first); end
        checks++;
        if (hs_last != 751) begin errors++; $display("FAIL line_hsync_last_x: got %0d, expected 751", hs_last); end
        checks++;
        if (n_ls != 1) begin errors++; $display("FAIL line_start_count: got %0d, expected 1", n_ls); end
        checks++;
        if ({ls_c, x_c, y_c} !== {1'b1, 10'd0, 10'd1}) begin
            errors++;
            $display("FAIL line_period: got ls=%b x=%0d y=%0d, expected ls=1 x=0 y=1", ls_c, x_c, y_c);
        end
    endtask

    task automatic test_wrap();
        int n = 0;
        while (!(x_c === 10'd799 && y_c === 10'd10) && n < 9000) begin step(1'b1); n++; end
        step(1'b1);
        checks++;
        if ({ls_c, fs_c, x_c, y_c} !== {2'b10, 10'd0, 10'd11}) begin
            errors++;
            $display("FAIL line_wrap_c: got ls=%b fs=%b x=%0d y=%0d after %0d cycles, expected ls=1 fs=0 x=0 y=11",
                     ls_c, fs_c, x_c, y_c, n);
        end
        n = 0;
        while (!(x_a === 10'd799 && y_a === 10'd12) && n < 12000) begin step(1'b1); n++; end
        step(1'b1);
        checks++;
        if ({ls_a, fs_a, de_a, x_a, y_a} !== {3'b111, 10'd0, 10'd0}) begin
            errors++;
            $display("FAIL frame_wrap_a: got ls=%b fs=%b de=%b x=%0d y=%0d after %0d cycles, expected 1 1 1 0 0",
                     ls_a, fs_a, de_a, x_a, y_a, n);
        end
    endtask

    task automatic test_frame_timing();
        int n_de = 0, n_de_blank = 0, n_vs = 0, vs_ymin = 1024, vs_ymax = -1, n_fs = 0;
        int b_hs_out = 0, b_hs_n = 0, b_vs_out = 0, b_fs_bad = 0, b_fs_last = -1;
        for (int i = 0; i < 10400; i++) begin
            if (de_a === 1'b1) n_de++;
            if (de_a === 1'b1 && y_a >= 10'd6) n_de_blank++;
            if (vsync_a === 1'b0) begin
                n_vs++;
                if (int'(y_a) < vs_ymin) vs_ymin = int'(y_a);
                if (int'(y_a) > vs_ymax) vs_ymax = int'(y_a);
            end
            if (fs_a === 1'b1) n_fs++;
            if (hsync_b === 1'b1) begin
                b_hs_n++;
                if (x_b !== 10'd5 && x_b !== 10'd6) b_hs_out++;
            end
            if (vsync_b === 1'b1 && y_b !== 10'd4) b_vs_out++;
            if (fs_b === 1'b1) begin
                if (b_fs_last >= 0 && t - b_fs_last != 48) b_fs_bad++;
                b_fs_last = t;
            end
            step(1'b1);
        end
        checks++;
        if (n_de != 3840) begin errors++; $display("FAIL frame_de_count: got %0d, expected 3840", n_de); end
        checks++;
        if (n_de_blank != 0) begin errors++; $display("FAIL frame_de_in_blank: got %0d, expected 0", n_de_blank); end
        checks++;
        if (n_vs != 1600) begin errors++; $display("FAIL frame_vsync_cycles: got %0d, expected 1600", n_vs); end
        checks++;
        if (vs_ymin != 8 || vs_ymax != 9) begin
            errors++;
            $display("FAIL frame_vsync_lines: got y %0d..%0d, expected 8..9", vs_ymin, vs_ymax);
        end
        checks++;
        if (n_fs != 1 || fs_a !== 1'b1) begin
            errors++;
            $display("FAIL frame_period_a: got %0d pulses, fs now %b, expected 1 pulse, fs now 1", n_fs, fs_a);
        end
        checks++;
        if (b_hs_out != 0 || b_hs_n != 2600) begin
            errors++;
            $display("FAIL small_hsync: got %0d outside x=5..6 and %0d total, expected 0 and 2600", b_hs_out, b_hs_n);
        end
        checks++;
        if (b_vs_out != 0) begin errors++; $display("FAIL small_vsync: got %0d outside y=4, expected 0", b_vs_out); end
        checks++;
        if (b_fs_bad != 0 || b_fs_last < 0) begin
            errors++;
            $display("FAIL small_frame_period: got %0d bad intervals, last at %0d, expected 0 bad", b_fs_bad, b_fs_last);
        end
    endtask

    task automatic test_mid_reset();
        int n = 0, n_fs = 0;
        while (!(x_a === 10'd700 && y_a === 10'd3) && n < 12000) begin step(1'b1); n++; end
        checks++;
        if (hsync_a !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_pre_sync: got hs=%b at x=%0d y=%0d after %0d cycles, expected 0", hsync_a, x_a, y_a, n);
        end
        step(1'b0);
        checks++;
        if ({hsync_a, vsync_a, de_a, ls_a, fs_a, x_a, y_a} !== {5'b11000, 20'd0}) begin
            errors++;
            $display("FAIL mid_reset_state_a: got hs=%b vs=%b de=%b ls=%b fs=%b x=%0d y=%0d, expected 1 1 0 0 0 0 0",
                     hsync_a, vsync_a, de_a, ls_a, fs_a, x_a, y_a);
        end
        step(1'b1);
        checks++;
        if ({hsync_a, vsync_a, de_a, ls_a, fs_a, x_a, y_a} !== {5'b11111, 20'd0}) begin
            errors++;
            $display("FAIL mid_reset_restart_a: got hs=%b vs=%b de=%b ls=%b fs=%b x=%0d y=%0d, expected 1 1 1 1 1 0 0",
                     hsync_a, vsync_a, de_a, ls_a, fs_a, x_a, y_a);
        end
        for (int i = 0; i < 96; i++) begin
            if (fs_b === 1'b1) n_fs++;
            step(1'b1);
        end
        checks++;
        if (n_fs != 2) begin errors++; $display("FAIL small_restart_frames: got %0d, expected 2", n_fs); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        t      = -1;
        resetn = 1'b0;
        fork
            sb_monitor();
        join_none
        test_reset();
        test_line_timing();
        test_wrap();
        test_frame_timing();
        test_mid_reset();
        @(negedge pixclk);
        #1;
        checks++;
        if (sbq[0].size() + sbq[1].size() + sbq[2].size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0",
                     sbq[0].size() + sbq[1].size() + sbq[2].size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Pixel-clock-domain raster timing generator that sits directly upstream of the DVI/TMDS test stage. It produces hsync, vsync, data-enable and pixel coordinates, so the pattern/encoder logic downstream can drive the TMDS lanes. It runs on the 25 MHz pixel clock from the clock block. Defaults give 640x480@60 (800x525 total).

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
HSYNC_POL, 0, hsync asserted level (0 = active-low)
VSYNC_POL, 0, vsync asserted level (0 = active-low)

Ports:
pixclk  in  1  pixel clock; sole clock
resetn  in  1  synchronous, active-low reset
hsync  out  1  horizontal sync, polarity per HSYNC_POL
vsync  out  1  vertical sync, polarity per VSYNC_POL
de  out  1  data enable; 1 inside the visible window
x  out  10  horizontal counter, 0..H_TOTAL-1
y  out  10  vertical counter, 0..V_TOTAL-1
line_start  out  1  1-cycle pulse at x==0
frame_start  out  1  1-cycle pulse at x==0, y==0

Behaviour:
- Interface: one clock, pixclk. Reset resetn is synchronous and active-low; it is sampled only on the pixclk rising edge.
- H_TOTAL = sum of the H_* parameters and V_TOTAL = sum of the V_* parameters. Both must be 1024 or less (10-bit counters). Elaboration fails otherwise.
- All outputs are flops, updated together. Each cycle they describe one coherent position (x,y). Sync and de are decoded from the same position as x and y.
- Reset (resetn=0 at an edge): x=0, y=0, de=0, line_start=0, frame_start=0. hsync=!HSYNC_POL and vsync=!VSYNC_POL, i.e. both inactive.
- First edge with resetn=1: outputs show position (0,0). de=1, line_start=1, frame_start=1, syncs inactive. There is no dead cycle.
- Counting: x increments each cycle. When x==H_TOTAL-1, x wraps to 0 on the next cycle and y advances. When y==V_TOTAL-1 and x wraps, y wraps to 0.
- de = (x < H_VISIBLE) && (y < V_VISIBLE).
- hsync is asserted for H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC, on every line including blank lines.
- vsync is asserted for V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC, for whole lines. It changes together with the y change at x==0.
- line_start = (x==0). frame_start = (x==0 && y==0).
- Position-to-output latency is 0: all outputs reflect the same count. The decode is computed from the next-count values, then registered.
- Reset mid-frame: the next cycle is reset state, regardless of position. Counting restarts at (0,0) as above. No partial sync pulse is held.
- There is no pause or enable input; the generator free-runs.
- Period: exactly H_TOTAL cycles per line and H_TOTAL*V_TOTAL cycles per frame.

Decomposition:
- Shared package video_timing_pkg holds:
  - COORD_W=10 constant.
  - Default 640x480 timing constants.
  - A typedef struct bundling hsync/vsync/de/x/y, for downstream pattern and encoder stages.
- One natural sub-module: timing_axis_counter. It is a parameterised counter with a wrap pulse and sync-window decode, instantiated twice. The vertical instance advances on the horizontal wrap.

Test Plan:
- Reset hold: resetn=0 for 5 cycles -> x=0, y=0, de=0, hsync=1, vsync=1, pulses 0. First cycle after release -> (0,0), de=1, frame_start=1.
- Line timing, defaults: de=1 for exactly 640 cycles (x 0..639). hsync=0 exactly for x 656..751 (96 cycles). line_start pulses every 800 cycles.
- Frame timing, defaults: vsync=0 for y 490..491 (1600 cycles). de=0 for all of y 480..524. frame_start period = 420000 cycles.
- Wrap: at x=799, y=524 -> next cycle (0,0) with frame_start=1. At x=799, y=10 -> next cycle (0,11) with line_start=1.
- Reset mid-frame: assert resetn=0 for 1 cycle at (700,300) -> reset state next cycle -> (0,0) with frame_start=1 the following cycle.
- Small config: H=4/1/2/1, V=3/1/1/1, HSYNC_POL=VSYNC_POL=1 -> 8x6 raster. hsync=1 only at x=5,6. vsync=1 only at y=4. 48-cycle frame.
